// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: walks the PC over a combinational ROM and queues
// {word, pc} pairs in a small FIFO for decode, with redirect and halt-on-zero.
module fetch_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int RESET_PC     = 0,
  parameter int DEPTH        = 2,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_adrs,
  input  logic [31:0]       imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted,
  output logic              misalign_err
);

  // DEPTH is 2 or 4, so the pointers wrap naturally at their width.
  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

  typedef enum logic {
    ST_FETCH,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       instrMem_q [DEPTH];
  logic [ADDR_W-1:0] pcMem_q    [DEPTH];

  logic pop;
  logic isZero;
  logic fetchEn;
  logic push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= PC_RST;
      count_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      misalign_q <= misalign_d;
    end
  end

  // A full FIFO being popped this cycle frees a slot, so fetch still proceeds.
  always_comb begin
    pop        = (count_q != '0) && out_ready;
    isZero     = HALT_ON_ZERO && (imem_instr == 32'h0000_0000);
    fetchEn    = (state_q == ST_FETCH) && !redirect_valid && ((count_q < DEPTH_C) || pop);
    push       = fetchEn && !isZero;

    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    misalign_d = 1'b0;

    if (redirect_valid) begin
      state_d    = ST_FETCH;
      pc_d       = {redirect_target[ADDR_W-1:2], 2'b00};
      count_d    = '0;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      misalign_d = |redirect_target[1:0];
    end else begin
      if (pop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      if (push) begin
        wrPtr_d = wrPtr_q + 1'b1;
        pc_d    = pc_q + ADDR_W'(4);
      end
      if (fetchEn && isZero) begin
        state_d = ST_HALT;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= imem_instr;
      pcMem_q[wrPtr_q]    <= pc_q;
    end
  end

  assign imem_adrs    = pc_q;
  assign out_valid    = (count_q != '0);
  assign out_instr    = out_valid ? instrMem_q[rdPtr_q] : 32'h0000_0000;
  assign out_pc       = out_valid ? pcMem_q[rdPtr_q] : '0;
  assign halted       = (state_q == ST_HALT);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, backpressure, halt, redirects,
// misalignment, PC wrap and reset priority, with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  imemAdrs;
  logic [31:0] imemInstr;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [6:0]  outPc;
  logic        redirectValid;
  logic [6:0]  redirectTarget;
  logic        halted;
  logic        misalignErr;

  logic [6:0]  imemAdrsW;
  logic        outValidW;
  logic [31:0] outInstrW;
  logic [6:0]  outPcW;
  logic        haltedW;
  logic        misalignErrW;

  logic [31:0] rom [32];
  int errors;
  int checks;

  fetch_ctrl #(.ADDR_W(7), .RESET_PC(0), .DEPTH(2), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .imem_adrs(imemAdrs), .imem_instr(imemInstr),
    .out_valid(outValid), .out_ready(outReady), .out_instr(outInstr), .out_pc(outPc),
    .redirect_valid(redirectValid), .redirect_target(redirectTarget),
    .halted(halted), .misalign_err(misalignErr)
  );

  // Second instance starts at the last word of the ROM to exercise PC wrap.
  fetch_ctrl #(.ADDR_W(7), .RESET_PC(124), .DEPTH(2), .HALT_ON_ZERO(1'b1)) dutWrap (
    .clk(clk), .rst(rst), .imem_adrs(imemAdrsW), .imem_instr(32'h0000_0013),
    .out_valid(outValidW), .out_ready(1'b1), .out_instr(outInstrW), .out_pc(outPcW),
    .redirect_valid(1'b0), .redirect_target(7'h00),
    .halted(haltedW), .misalign_err(misalignErrW)
  );

  assign imemInstr = rom[imemAdrs[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    redirectValid = 1'b0;
    redirectTarget = 7'h00;
    outReady = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    redirectValid = 1'b0;
    outReady = 1'b0;
    step();
    step();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0h want 0", outValid); end
    checks++; if (outInstr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h want 00000000", outInstr); end
    checks++; if (outPc !== 7'h00) begin errors++; $display("[TB] FAIL rst_outpc got %0d want 0", outPc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL rst_halted got %0h want 0", halted); end
    checks++; if (misalignErr !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign got %0h want 0", misalignErr); end
    checks++; if (imemAdrs !== 7'd0) begin errors++; $display("[TB] FAIL rst_adrs got %0d want 0", imemAdrs); end
    checks++; if (imemAdrsW !== 7'd124) begin errors++; $display("[TB] FAIL rst_adrs_wrap got %0d want 124", imemAdrsW); end
    rst = 1'b0;
  endtask

  task automatic test_stream;
    do_reset();
    outReady = 1'b1;
    step();
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid got %0h want 1", outValid); end
    checks++; if (outInstr !== 32'h00450693) begin errors++; $display("[TB] FAIL stream_w0 got %h want 00450693", outInstr); end
    checks++; if (outPc !== 7'd0) begin errors++; $display("[TB] FAIL stream_pc0 got %0d want 0", outPc); end
    checks++; if (imemAdrs !== 7'd4) begin errors++; $display("[TB] FAIL stream_adrs1 got %0d want 4", imemAdrs); end
    step();
    checks++; if (outInstr !== 32'h00100713) begin errors++; $display("[TB] FAIL stream_w1 got %h want 00100713", outInstr); end
    checks++; if (outPc !== 7'd4) begin errors++; $display("[TB] FAIL stream_pc1 got %0d want 4", outPc); end
    checks++; if (imemAdrs !== 7'd8) begin errors++; $display("[TB] FAIL stream_adrs2 got %0d want 8", imemAdrs); end
    for (int k = 3; k <= 5; k++) begin
      step();
      checks++; if (outPc !== 7'(4 * (k - 1))) begin errors++; $display("[TB] FAIL stream_pc%0d got %0d want %0d", k, outPc, 4 * (k - 1)); end
      checks++; if (imemAdrs !== 7'(4 * k)) begin errors++; $display("[TB] FAIL stream_adrs%0d got %0d want %0d", k, imemAdrs, 4 * k); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (outInstr !== 32'h00450693 || outPc !== 7'd0 || outValid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold%0d got v=%0h %h @%0d want v=1 00450693 @0", k, outValid, outInstr, outPc);
      end
    end
    checks++; if (imemAdrs !== 7'd8) begin errors++; $display("[TB] FAIL bp_pc_hold got %0d want 8", imemAdrs); end
    outReady = 1'b1;
    step();
    checks++; if (outPc !== 7'd4) begin errors++; $display("[TB] FAIL bp_rel1 got %0d want 4", outPc); end
    checks++; if (imemAdrs !== 7'd12) begin errors++; $display("[TB] FAIL bp_fullpop_fetch got %0d want 12", imemAdrs); end
    step();
    checks++; if (outPc !== 7'd8 || outInstr !== 32'h00b76463) begin errors++; $display("[TB] FAIL bp_rel2 got %h @%0d want 00b76463 @8", outInstr, outPc); end
    step();
    checks++; if (outPc !== 7'd12) begin errors++; $display("[TB] FAIL bp_rel3 got %0d want 12", outPc); end
  endtask

  task automatic test_halt;
    do_reset();
    outReady = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      checks++; if (outValid !== 1'b1 || outPc !== 7'(4 * (k - 1)) || outInstr !== rom[k - 1] || halted !== 1'b0) begin
        errors++; $display("[TB] FAIL halt_word%0d got v=%0h %h @%0d h=%0h want v=1 %h @%0d h=0",
                           k - 1, outValid, outInstr, outPc, halted, rom[k - 1], 4 * (k - 1));
      end
    end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_set got %0h want 1", halted); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL halt_noenq got %0h want 0", outValid); end
    step();
    checks++; if (imemAdrs !== 7'd76 || halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_hold got pc=%0d h=%0h want pc=76 h=1", imemAdrs, halted); end
    redirectValid = 1'b1;
    redirectTarget = 7'd8;
    step();
    redirectValid = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_clear got %0h want 0", halted); end
    checks++; if (imemAdrs !== 7'd8 || outValid !== 1'b0) begin errors++; $display("[TB] FAIL halt_redir got pc=%0d v=%0h want pc=8 v=0", imemAdrs, outValid); end
    step();
    checks++; if (outValid !== 1'b1 || outPc !== 7'd8 || outInstr !== 32'h00b76463) begin
      errors++; $display("[TB] FAIL halt_resume got v=%0h %h @%0d want v=1 00b76463 @8", outValid, outInstr, outPc);
    end
  endtask

  task automatic test_redirect_midstream;
    do_reset();
    outReady = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    checks++; if (outPc !== 7'd16) begin errors++; $display("[TB] FAIL mid_head got %0d want 16", outPc); end
    redirectValid = 1'b1;
    redirectTarget = 7'd72;
    step();
    redirectValid = 1'b0;
    checks++; if (outValid !== 1'b0 || imemAdrs !== 7'd72) begin errors++; $display("[TB] FAIL mid_flush got v=%0h pc=%0d want v=0 pc=72", outValid, imemAdrs); end
    step();
    checks++; if (outValid !== 1'b1 || outPc !== 7'd72 || outInstr !== 32'hfc1ff06f) begin
      errors++; $display("[TB] FAIL mid_target got v=%0h %h @%0d want v=1 fc1ff06f @72", outValid, outInstr, outPc);
    end
    step();
    checks++; if (halted !== 1'b1 || outValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_zero got h=%0h v=%0h want h=1 v=0", halted, outValid); end
  endtask

  task automatic test_misalign_back_to_back;
    do_reset();
    redirectValid = 1'b1;
    redirectTarget = 7'h0A;
    step();
    redirectValid = 1'b0;
    checks++; if (misalignErr !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse got %0h want 1", misalignErr); end
    checks++; if (imemAdrs !== 7'd8) begin errors++; $display("[TB] FAIL mis_pc got %0d want 8", imemAdrs); end
    step();
    checks++; if (misalignErr !== 1'b0) begin errors++; $display("[TB] FAIL mis_oneshot got %0h want 0", misalignErr); end
    checks++; if (outPc !== 7'd8 || outInstr !== 32'h00b76463) begin errors++; $display("[TB] FAIL mis_word got %h @%0d want 00b76463 @8", outInstr, outPc); end
    redirectValid = 1'b1;
    redirectTarget = 7'h11;
    step();
    checks++; if (misalignErr !== 1'b1 || outValid !== 1'b0 || imemAdrs !== 7'd16) begin
      errors++; $display("[TB] FAIL b2b_first got m=%0h v=%0h pc=%0d want m=1 v=0 pc=16", misalignErr, outValid, imemAdrs);
    end
    redirectTarget = 7'h20;
    step();
    redirectValid = 1'b0;
    checks++; if (misalignErr !== 1'b0 || outValid !== 1'b0 || imemAdrs !== 7'd32) begin
      errors++; $display("[TB] FAIL b2b_second got m=%0h v=%0h pc=%0d want m=0 v=0 pc=32", misalignErr, outValid, imemAdrs);
    end
    step();
    checks++; if (outPc !== 7'd32 || outInstr !== rom[8]) begin errors++; $display("[TB] FAIL b2b_word got %h @%0d want %h @32", outInstr, outPc, rom[8]); end
  endtask

  task automatic test_wrap;
    do_reset();
    checks++; if (imemAdrsW !== 7'd124) begin errors++; $display("[TB] FAIL wrap_start got %0d want 124", imemAdrsW); end
    step();
    checks++; if (imemAdrsW !== 7'd0) begin errors++; $display("[TB] FAIL wrap_next got %0d want 0", imemAdrsW); end
    checks++; if (outValidW !== 1'b1 || outPcW !== 7'd124) begin errors++; $display("[TB] FAIL wrap_word got v=%0h @%0d want v=1 @124", outValidW, outPcW); end
  endtask

  task automatic test_reset_priority;
    do_reset();
    for (int k = 1; k <= 3; k++) step();
    checks++; if (outValid !== 1'b1 || imemAdrs !== 7'd8) begin errors++; $display("[TB] FAIL rp_full got v=%0h pc=%0d want v=1 pc=8", outValid, imemAdrs); end
    rst = 1'b1;
    redirectValid = 1'b1;
    redirectTarget = 7'h29;
    step();
    rst = 1'b0;
    redirectValid = 1'b0;
    checks++; if (outValid !== 1'b0 || outInstr !== 32'h0) begin errors++; $display("[TB] FAIL rp_flush got v=%0h %h want v=0 00000000", outValid, outInstr); end
    checks++; if (imemAdrs !== 7'd0) begin errors++; $display("[TB] FAIL rp_pc got %0d want 0", imemAdrs); end
    checks++; if (halted !== 1'b0 || misalignErr !== 1'b0) begin errors++; $display("[TB] FAIL rp_flags got h=%0h m=%0h want h=0 m=0", halted, misalignErr); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013 | (32'(i + 1) << 12);
    rom[0]  = 32'h00450693;
    rom[1]  = 32'h00100713;
    rom[2]  = 32'h00b76463;
    rom[18] = 32'hfc1ff06f;
    rom[19] = 32'h00000000;
    rst = 1'b1;
    outReady = 1'b0;
    redirectValid = 1'b0;
    redirectTarget = 7'h00;

    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_redirect_midstream();
    test_misalign_back_to_back();
    test_wrap();
    test_reset_priority();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 128-byte instruction ROM. It holds the program counter, drives the ROM byte address, and captures the combinational 32-bit instruction word into a small FIFO. The FIFO feeds decode over a valid/ready handshake. It accepts branch/jump redirects from execute and halts on an all-zero word, which marks the end of the program.

Parameters:
ADDR_W, 7, byte-address width of the instruction ROM
RESET_PC, 0, PC loaded on reset; must be word-aligned
DEPTH, 2, fetch FIFO entries (2 or 4)
HALT_ON_ZERO, 1, 1 = fetching 32'h00000000 halts fetch and the word is not enqueued

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_adrs  out  ADDR_W  byte address to ROM, combinational = pc
imem_instr  in  32  ROM data_out for imem_adrs, same cycle
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction word
out_pc  out  ADDR_W  byte address the head word was fetched from
redirect_valid  in  1  one-cycle redirect request from execute
redirect_target  in  ADDR_W  new byte PC
halted  out  1  fetch stopped on zero word
misalign_err  out  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, halted=0, misalign_err=0. Reset mid-operation discards all FIFO entries. Reset overrides redirect.
- imem_adrs = pc at all times. The ROM is combinational, so there is zero-cycle fetch latency.
- pop = out_valid && out_ready. The head is removed at the edge.
- fetch_en = !halted && !redirect_valid && (count<DEPTH || pop). A full FIFO with a simultaneous pop still fetches.
- Zero-word check: zero = HALT_ON_ZERO && imem_instr==32'h0.
- If fetch_en && !zero: push {imem_instr, pc} at the tail, pc <= pc+4 mod 2^ADDR_W (124 -> 0 wrap, no flag).
- If fetch_en && zero: no push, pc unchanged, halted<=1. Entries already queued still drain normally.
- If !fetch_en: pc holds and there is no push.
- Latency: a word at pc is visible on out_* the cycle after its fetch edge. Sustained throughput is 1 word/cycle when out_ready=1.
- out_instr and out_pc are stable while out_valid && !out_ready. out_valid never drops without a pop, redirect, or reset.
- Redirect (redirect_valid=1), precedence below reset:
  - A pop in the same cycle still completes; decode owns that word.
  - The whole FIFO is flushed (count<=0) and no fetch occurs this cycle.
  - pc <= {redirect_target[ADDR_W-1:2], 2'b00} and halted <= 0.
  - misalign_err <= (redirect_target[1:0] != 0) for one cycle; otherwise misalign_err <= 0.
  - The first word from the new pc appears on out_* two cycles after the redirect cycle.
- Back-to-back redirects: the last one wins. Each one flushes.
- FIFO: circular buffer with rd/wr pointers and count. Simultaneous push and pop when full is legal; count is unchanged. Push when empty without pop gives out_valid=1 next cycle (no bypass to the current cycle).
- halted stays 1 until redirect or reset. It does not require the FIFO to be empty.

Test Plan:
- Reset, out_ready=1, ROM word0=32'h00450693, word1=32'h00100713 -> cycle 1 out_valid=1 out_instr=00450693 out_pc=0; cycle 2 out_instr=00100713 out_pc=4; imem_adrs steps 0,4,8,... each cycle.
- Backpressure: out_ready=0 for 5 cycles after reset, DEPTH=2 -> count saturates at 2, pc holds at 8, out_instr stays 00450693 with out_pc=0. Release out_ready -> words at 0,4,8 delivered on consecutive cycles, none lost or duplicated.
- Program of 19 words followed by zero at address 76 -> halted=1 after the fetch at pc=76, pc stays 76, all 19 words delivered in order. Redirect to 8 -> halted=0, next out_pc=8 with out_instr=00b76463.
- Redirect mid-stream: pop of out_pc=16 with redirect_target=72 in the same cycle -> word 16 consumed, queued words flushed, two cycles later out_pc=72 out_instr=fc1ff06f.
- Misaligned redirect: target=7'h0A -> misalign_err pulses for exactly 1 cycle, pc=8. Wrap test: RESET_PC=124 with a nonzero word at 124 -> next fetch address is 0.
- Reset asserted while FIFO full and a redirect is pending -> next cycle out_valid=0, pc=RESET_PC, halted=0, misalign_err=0.
